// File: rtl/gb80_pkg.sv
// gb80 shared types and constants.
// Fetch state encodings, open-bus byte, machine-cycle length.
package gb80_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_READ = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } fetch_state_t;

  localparam logic [7:0] OPEN_BUS_BYTE = 8'hFF;
  localparam int T_STATES = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit decoder-side and memory-side signals.
// master = fetch unit, slave = decoder/bus environment.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH = 16
) ();

  logic                  i_mem_rd_en;
  logic                  i_pc_load;
  logic [PC_WIDTH-1:0]   i_pc_load_val;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_busy;
  logic [PC_WIDTH-1:0]   o_pc;
  logic [PC_WIDTH-1:0]   o_bus_addr;
  logic                  o_bus_rd;
  logic [DATA_WIDTH-1:0] i_bus_data;
  logic                  i_bus_ack;
  logic                  o_bus_err;

  modport master (
    input  i_mem_rd_en, i_pc_load, i_pc_load_val,
    input  i_bus_data, i_bus_ack,
    output o_data, o_data_valid, o_busy, o_pc,
    output o_bus_addr, o_bus_rd, o_bus_err
  );

  modport slave (
    output i_mem_rd_en, i_pc_load, i_pc_load_val,
    output i_bus_data, i_bus_ack,
    input  o_data, o_data_valid, o_busy, o_pc,
    input  o_bus_addr, o_bus_rd, o_bus_err
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: load beats increment.
// Increment wraps modulo 2^PC_WIDTH.
module pc_reg #(
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_load,
  input  logic [PC_WIDTH-1:0] i_load_val,
  input  logic                i_inc,
  output logic [PC_WIDTH-1:0] o_pc
);

  // PC update: jump load first, then sequential advance
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pc <= RESET_PC;
    end else if (i_load) begin
      o_pc <= i_load_val;
    end else if (i_inc) begin
      o_pc <= o_pc + PC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// gb80 bus-side byte fetcher: one byte per machine cycle.
// T1 addr, T2 read, T3 wait states, T4 deliver.
module fetch_unit
  import gb80_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000,
  parameter int MAX_WAIT = 15
) (
  input logic          i_clk,
  input logic          i_reset_n,
  fetch_unit_if.master fu
);

  fetch_state_t state_q, state_d;
  logic pending_q, pending_d;
  logic [7:0] wait_q, wait_d;
  logic timeout;
  logic skip_inc_q;
  logic in_fetch;
  logic pc_inc;
  logic [PC_WIDTH-1:0] pc;

  logic [DATA_WIDTH-1:0] data_q;
  logic valid_q, err_q, busy_q, rd_q;
  logic [PC_WIDTH-1:0] addr_q;

  assign in_fetch = (state_q == S_ADDR) ||
                    (state_q == S_READ) ||
                    (state_q == S_WAIT);
  assign pc_inc = (state_q == S_DONE) && !skip_inc_q;

  pc_reg #(
    .PC_WIDTH(PC_WIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (fu.i_pc_load),
    .i_load_val(fu.i_pc_load_val),
    .i_inc     (pc_inc),
    .o_pc      (pc)
  );

  // Next state, wait-state counting and timeout detection
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    timeout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fu.i_mem_rd_en || pending_q) state_d = S_ADDR;
      end
      S_ADDR: begin
        state_d = S_READ;
        wait_d  = '0;
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        if (fu.i_bus_ack) begin
          state_d = S_DONE;
        end else if (wait_q == 8'(MAX_WAIT)) begin
          state_d = S_DONE;
          timeout = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DONE: state_d = pending_q ? S_ADDR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One-deep request queue: later strobes are dropped
  always_comb begin
    pending_d = pending_q;
    if (state_q != S_IDLE && fu.i_mem_rd_en && !pending_q) begin
      pending_d = 1'b1;
    end else if (state_d == S_ADDR) begin
      pending_d = 1'b0;
    end
  end

  // State, queue and counter registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
    end
  end

  // A jump mid-fetch replaces the T4 increment
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      skip_inc_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      skip_inc_q <= 1'b0;
    end else if (fu.i_pc_load && in_fetch) begin
      skip_inc_q <= 1'b1;
    end
  end

  // Registered bus and decoder outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      valid_q <= (state_d == S_DONE);
      err_q   <= timeout;
      busy_q  <= (state_d != S_IDLE);
      rd_q    <= (state_d == S_READ) || (state_d == S_WAIT);
      if (state_q == S_ADDR) addr_q <= pc;
      if (state_q == S_WAIT && state_d == S_DONE) begin
        data_q <= timeout ? DATA_WIDTH'(OPEN_BUS_BYTE)
                          : fu.i_bus_data;
      end
    end
  end

  assign fu.o_data       = data_q;
  assign fu.o_data_valid = valid_q;
  assign fu.o_bus_err    = err_q;
  assign fu.o_busy       = busy_q;
  assign fu.o_bus_rd     = rd_q;
  assign fu.o_bus_addr   = addr_q;
  assign fu.o_pc         = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a delay-programmable memory.
// Inputs change 1ns after rising edges; outputs checked there.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [7:0] mem [0:65535];
  int   rd_cnt;
  int   ack_delay;
  logic ack_en;

  fetch_unit_if #(.DATA_WIDTH(8), .PC_WIDTH(16)) fu ();

  fetch_unit #(
    .DATA_WIDTH(8),
    .PC_WIDTH(16),
    .RESET_PC(16'h0000),
    .MAX_WAIT(15)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .fu       (fu)
  );

  always #5 clk = ~clk;

  // memory model: ack after ack_delay wait cycles
  always @(negedge clk) begin
    if (fu.o_bus_rd) rd_cnt = rd_cnt + 1;
    else rd_cnt = 0;
    fu.i_bus_ack  = ack_en && fu.o_bus_rd &&
                    (rd_cnt >= ack_delay + 2);
    fu.i_bus_data = mem[fu.o_bus_addr];
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    n_vec = 0;
    n_err = 0;
    rd_cnt = 0;
    ack_delay = 0;
    ack_en = 1'b1;
    fu.i_mem_rd_en = 1'b0;
    fu.i_pc_load = 1'b0;
    fu.i_pc_load_val = '0;
    fu.i_bus_ack = 1'b0;
    fu.i_bus_data = '0;
    mem[16'h0000] = 8'h3E;

    // reset state
    tick(2);
    chk("rst_data", fu.o_data, 8'h00);
    chk("rst_valid", fu.o_data_valid, 1'b0);
    chk("rst_busy", fu.o_busy, 1'b0);
    chk("rst_rd", fu.o_bus_rd, 1'b0);
    chk("rst_err", fu.o_bus_err, 1'b0);
    chk("rst_pc", fu.o_pc, 16'h0000);
    chk("rst_addr", fu.o_bus_addr, 16'h0000);
    rst_n = 1'b1;

    // single fetch, zero wait
    fu.i_mem_rd_en = 1'b1;
    tick();
    fu.i_mem_rd_en = 1'b0;
    chk("t1_busy_c1", fu.o_busy, 1'b1);
    chk("t1_rd_c1", fu.o_bus_rd, 1'b0);
    tick();
    chk("t1_rd_c2", fu.o_bus_rd, 1'b1);
    chk("t1_addr", fu.o_bus_addr, 16'h0000);
    tick();
    chk("t1_valid_c3", fu.o_data_valid, 1'b0);
    tick();
    chk("t1_valid_c4", fu.o_data_valid, 1'b1);
    chk("t1_data", fu.o_data, 8'h3E);
    chk("t1_err", fu.o_bus_err, 1'b0);
    tick();
    chk("t1_valid_c5", fu.o_data_valid, 1'b0);
    chk("t1_pc", fu.o_pc, 16'h0001);
    chk("t1_busy_c5", fu.o_busy, 1'b0);
    chk("t1_hold", fu.o_data, 8'h3E);

    // back-to-back with pending, third strobe dropped
    mem[16'h0000] = 8'h06;
    mem[16'h0001] = 8'h42;
    do_reset();
    fu.i_mem_rd_en = 1'b1;
    tick(3);
    fu.i_mem_rd_en = 1'b0;
    tick();
    chk("t2_valid_c4", fu.o_data_valid, 1'b1);
    chk("t2_data0", fu.o_data, 8'h06);
    tick();
    chk("t2_valid_c5", fu.o_data_valid, 1'b0);
    chk("t2_busy_c5", fu.o_busy, 1'b1);
    tick();
    chk("t2_addr1", fu.o_bus_addr, 16'h0001);
    tick(2);
    chk("t2_valid_c8", fu.o_data_valid, 1'b1);
    chk("t2_data1", fu.o_data, 8'h42);
    tick();
    chk("t2_busy_c9", fu.o_busy, 1'b0);
    tick();
    chk("t2_busy_c10", fu.o_busy, 1'b0);
    chk("t2_pc", fu.o_pc, 16'h0002);

    // ack delayed by three wait states
    mem[16'h0002] = 8'hA5;
    ack_delay = 3;
    fu.i_mem_rd_en = 1'b1;
    tick();
    fu.i_mem_rd_en = 1'b0;
    tick();
    chk("t3_rd_c2", fu.o_bus_rd, 1'b1);
    tick(4);
    chk("t3_rd_c6", fu.o_bus_rd, 1'b1);
    chk("t3_valid_c6", fu.o_data_valid, 1'b0);
    tick();
    chk("t3_valid_c7", fu.o_data_valid, 1'b1);
    chk("t3_data", fu.o_data, 8'hA5);
    chk("t3_rd_c7", fu.o_bus_rd, 1'b0);
    tick();
    chk("t3_pc", fu.o_pc, 16'h0003);

    // no ack: timeout after MAX_WAIT
    ack_en = 1'b0;
    fu.i_mem_rd_en = 1'b1;
    tick();
    fu.i_mem_rd_en = 1'b0;
    tick(17);
    chk("to_valid_c18", fu.o_data_valid, 1'b0);
    chk("to_rd_c18", fu.o_bus_rd, 1'b1);
    tick();
    chk("to_valid_c19", fu.o_data_valid, 1'b1);
    chk("to_data", fu.o_data, 8'hFF);
    chk("to_err_c19", fu.o_bus_err, 1'b1);
    tick();
    chk("to_err_c20", fu.o_bus_err, 1'b0);
    chk("to_pc", fu.o_pc, 16'h0004);
    ack_en = 1'b1;
    ack_delay = 0;

    // load with request, PC wrap
    mem[16'hFFFF] = 8'hC3;
    fu.i_mem_rd_en = 1'b1;
    fu.i_pc_load = 1'b1;
    fu.i_pc_load_val = 16'hFFFF;
    tick();
    fu.i_mem_rd_en = 1'b0;
    fu.i_pc_load = 1'b0;
    chk("t4_pc_load", fu.o_pc, 16'hFFFF);
    tick();
    chk("t4_addr", fu.o_bus_addr, 16'hFFFF);
    tick(2);
    chk("t4_valid", fu.o_data_valid, 1'b1);
    chk("t4_data", fu.o_data, 8'hC3);
    tick();
    chk("t4_wrap", fu.o_pc, 16'h0000);

    // jump during wait states
    ack_delay = 2;
    fu.i_mem_rd_en = 1'b1;
    tick();
    fu.i_mem_rd_en = 1'b0;
    tick(2);
    fu.i_pc_load = 1'b1;
    fu.i_pc_load_val = 16'h0150;
    tick();
    fu.i_pc_load = 1'b0;
    chk("jw_pc", fu.o_pc, 16'h0150);
    chk("jw_addr", fu.o_bus_addr, 16'h0000);
    tick(2);
    chk("jw_valid", fu.o_data_valid, 1'b1);
    chk("jw_data", fu.o_data, 8'h06);
    tick();
    chk("jw_pc_after", fu.o_pc, 16'h0150);
    mem[16'h0150] = 8'h77;
    ack_delay = 0;
    fu.i_mem_rd_en = 1'b1;
    tick();
    fu.i_mem_rd_en = 1'b0;
    tick();
    chk("jw_addr2", fu.o_bus_addr, 16'h0150);
    tick(2);
    chk("jw_data2", fu.o_data, 8'h77);

    // asynchronous reset in S_WAIT
    tick();
    ack_en = 1'b0;
    fu.i_mem_rd_en = 1'b1;
    tick();
    fu.i_mem_rd_en = 1'b0;
    tick(2);
    chk("ar_rd_pre", fu.o_bus_rd, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_rd_async", fu.o_bus_rd, 1'b0);
    chk("ar_busy", fu.o_busy, 1'b0);
    chk("ar_pc", fu.o_pc, 16'h0000);
    tick(2);
    chk("ar_valid", fu.o_data_valid, 1'b0);
    rst_n = 1'b1;
    ack_en = 1'b1;
    fu.i_mem_rd_en = 1'b1;
    tick();
    fu.i_mem_rd_en = 1'b0;
    tick();
    chk("ar_addr", fu.o_bus_addr, 16'h0000);
    tick(2);
    chk("ar_valid2", fu.o_data_valid, 1'b1);
    chk("ar_data", fu.o_data, 8'h06);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Bus-side byte fetcher: the data source for the GB80 decoder. It answers the decoder's `mem_rd_en` strobe by reading one byte at the program counter from the external memory bus and returning it on the decoder's data input, then advancing the PC. Each fetch is one 4-T-state machine cycle, extended by wait states on a slow bus acknowledge. The unit sits between the decoder/control block and the memory bus arbiter.

## Interface
- `DATA_WIDTH`, 8, byte width of the data bus.
- `PC_WIDTH`, 16, width of the program counter and bus address.
- `RESET_PC`, 16'h0000, PC value after reset.
- `MAX_WAIT`, 15, maximum wait states tolerated before a fetch is aborted (1..255).
- `i_clk`  in  1  single system clock; all logic on its rising edge.
- `i_reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_mem_rd_en`  in  1  fetch request strobe from the decoder.
- `i_pc_load`  in  1  load the PC from `i_pc_load_val` (jumps).
- `i_pc_load_val`  in  PC_WIDTH  new PC value.
- `o_data`  out  DATA_WIDTH  fetched byte, drives the decoder `i_data`; held until the next fetch completes.
- `o_data_valid`  out  1  one-cycle pulse when `o_data` is updated.
- `o_busy`  out  1  high in every state except S_IDLE.
- `o_pc`  out  PC_WIDTH  current PC.
- `o_bus_addr`  out  PC_WIDTH  memory address; equals the PC latched at S_ADDR.
- `o_bus_rd`  out  1  memory read strobe.
- `i_bus_data`  in  DATA_WIDTH  memory read data, valid when `i_bus_ack`=1.
- `i_bus_ack`  in  1  memory acknowledge.
- `o_bus_err`  out  1  one-cycle pulse on a wait-state timeout.

## Operation
- States: S_IDLE, S_ADDR (T1), S_READ (T2), S_WAIT (T3, repeats), S_DONE (T4).
- S_IDLE -> S_ADDR when `i_mem_rd_en`=1 or `pending`=1. Otherwise stay in S_IDLE.
- S_ADDR -> S_READ unconditionally. The PC is latched into `o_bus_addr`.
- S_READ -> S_WAIT unconditionally.
- S_WAIT -> S_DONE when `i_bus_ack`=1. The byte is captured from `i_bus_data`.
- In S_WAIT with `i_bus_ack`=0: the wait counter increments. When the counter reaches MAX_WAIT, the unit goes to S_DONE with byte 8'hFF (open bus) and pulses `o_bus_err` in S_DONE.
- S_DONE: `o_data` is updated, `o_data_valid`=1, and PC <= PC+1 modulo 2^PC_WIDTH (16'hFFFF wraps to 16'h0000). Next state is S_ADDR if `pending`, else S_IDLE.
- `o_bus_rd`=1 only in S_READ and S_WAIT.
- Request queue is one deep. If `i_mem_rd_en`=1 while not in S_IDLE, `pending` is set. It clears on the S_IDLE/S_DONE -> S_ADDR transition. Further strobes while `pending` is already set are dropped.
- PC load:
  - `i_pc_load` takes effect at the next clock edge in any state.
  - In S_DONE it overrides the increment.
  - Mid-fetch, the in-flight byte is still delivered and the address already on the bus is unaffected.
  - Load and request together in S_IDLE: the fetch uses the loaded value.
- Reset (asynchronous, any state):
  - state = S_IDLE, PC = RESET_PC.
  - `o_data`=0, `o_data_valid`=0, `o_bus_rd`=0, `o_bus_addr`=RESET_PC, `o_bus_err`=0, `o_busy`=0.
  - `pending` and the wait counter are cleared.
  - An aborted fetch produces no valid pulse.

## Timing
- All outputs are registered.
- Request sampled at edge n (S_IDLE) -> S_ADDR at n+1, `o_bus_rd` high from n+2, ack with zero wait sampled at n+3 -> `o_data_valid` at n+4. Minimum latency is 4 cycles: one machine cycle.
- Each cycle of `i_bus_ack`=0 in S_WAIT adds one cycle of latency. The worst case is 4+MAX_WAIT cycles.
- Back-to-back fetches with `pending` set: one valid pulse every 4 cycles with no idle gap.
- `i_bus_ack` outside S_WAIT is ignored.

## Structure
- Shared package `gb80_pkg`:
  - fetch state encodings;
  - OPEN_BUS_BYTE = 8'hFF;
  - the T-state count of 4, shared with the decoder's cycle counter.
- One natural sub-module, `pc_reg`: PC register with load/increment priority and wrap-around. The FSM, pending flag and wait counter stay in `fetch_unit`.

## Test plan
- Reset release, request at cycle 0, memory[16'h0000]=8'h3E, ack immediate -> `o_bus_addr`=16'h0000, `o_data`=8'h3E with a valid pulse at cycle 4, `o_pc`=16'h0001.
- Two strobes 1 cycle apart, bytes 8'h06/8'h42 -> valid pulses at cycles 4 and 8, addresses 0 then 1; a third strobe during the pending window is dropped.
- Ack delayed 3 cycles -> valid at cycle 7, `o_bus_rd` high cycles 2–6; with MAX_WAIT=15 and no ack -> `o_data`=8'hFF, `o_bus_err` pulse, PC still increments.
- PC=16'hFFFF, fetch -> address 16'hFFFF, then `o_pc`=16'h0000; `i_pc_load`=16'h0150 during S_WAIT -> in-flight byte delivered, then `o_pc`=16'h0150.
- `i_reset_n` low during S_WAIT -> `o_bus_rd` drops without a clock edge, no valid pulse, `o_pc`=RESET_PC, next request fetches from RESET_PC.
